// File: rtl/cic_comp_pkg.sv
// rtl/cic_comp_pkg.sv - shared constants, coefficient set and FSM states for the CIC compensation FIR
package cic_comp_pkg;

  localparam int NUM_TAPS   = 11;
  localparam int COEF_WIDTH = 16;
  localparam int COEF_FRAC  = 14;
  localparam int PTR_W      = 4;

  // Q2.14 taps, symmetric, summing to 16384 so DC gain is exactly 1.0
  localparam logic signed [COEF_WIDTH-1:0] COEFS [NUM_TAPS] = '{
    -16'sd64,   16'sd192,  -16'sd640,  16'sd1536, -16'sd3072,
    16'sd20480,
    -16'sd3072, 16'sd1536, -16'sd640,  16'sd192,  -16'sd64
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_TAPS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(NUM_TAPS - 1) : p - PTR_W'(1);
  endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// rtl/cic_comp_fir_if.sv - sample-in / sample-out bundle between the CIC decimator and the compensation FIR
interface cic_comp_fir_if #(
  parameter int INPUT_WIDTH  = 15,
  parameter int OUTPUT_WIDTH = 16
);

  logic                           in_valid;
  logic signed [INPUT_WIDTH-1:0]  in_data;
  logic signed [OUTPUT_WIDTH-1:0] out_data;
  logic                           out_valid;
  logic                           busy;
  logic                           overrun;

  modport master (
    output in_valid, in_data,
    input  out_data, out_valid, busy, overrun
  );

  modport slave (
    input  in_valid, in_data,
    output out_data, out_valid, busy, overrun
  );

endinterface

// File: rtl/cic_comp_coef_rom.sv
// rtl/cic_comp_coef_rom.sv - combinational tap index to coefficient lookup
module cic_comp_coef_rom
  import cic_comp_pkg::*;
(
  input  logic [PTR_W-1:0]             i_tap,
  output logic signed [COEF_WIDTH-1:0] o_coef
);

  // Indices past the last tap read as zero so an overrun index cannot disturb the sum
  always_comb begin
    o_coef = '0;
    if (i_tap < PTR_W'(NUM_TAPS)) begin
      o_coef = COEFS[i_tap];
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - 11-tap CIC droop compensation FIR with a single time-shared multiplier
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int INPUT_WIDTH  = 15,
  parameter int OUTPUT_WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  cic_comp_fir_if.slave bus
);

  localparam int ACC_W  = INPUT_WIDTH + COEF_WIDTH + 4;
  localparam int PROD_W = INPUT_WIDTH + COEF_WIDTH;
  localparam int RND_W  = ACC_W - COEF_FRAC;

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (COEF_FRAC - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'(2 ** (OUTPUT_WIDTH - 1) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN  = RND_W'(-(2 ** (OUTPUT_WIDTH - 1)));

  state_t r_state;
  state_t w_state_next;

  logic signed [INPUT_WIDTH-1:0]  r_dline [NUM_TAPS];
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [PTR_W-1:0]               r_tap;
  logic signed [ACC_W-1:0]        r_acc;
  logic signed [OUTPUT_WIDTH-1:0] r_out_data;
  logic                           r_out_valid;
  logic                           r_overrun;

  logic signed [COEF_WIDTH-1:0]   w_coef;
  logic signed [INPUT_WIDTH-1:0]  w_tap_data;
  logic signed [PROD_W-1:0]       w_prod;
  logic signed [RND_W-1:0]        w_scaled;
  logic signed [OUTPUT_WIDTH-1:0] w_sat;
  logic                           w_last_tap;
  logic                           w_drop;

  cic_comp_coef_rom u_coef_rom (
    .i_tap  (r_tap),
    .o_coef (w_coef)
  );

  assign w_tap_data = r_dline[r_rd_ptr];
  assign w_prod     = w_tap_data * w_coef;
  assign w_last_tap = (r_tap == PTR_W'(NUM_TAPS - 1));
  assign w_drop     = bus.in_valid && (r_state != IDLE);

  // Round half up at the Q14 boundary, then clamp to the output range
  assign w_scaled = RND_W'((r_acc + RND_HALF) >>> COEF_FRAC);

  always_comb begin
    w_sat = w_scaled[OUTPUT_WIDTH-1:0];
    if (w_scaled > SAT_MAX) begin
      w_sat = SAT_MAX[OUTPUT_WIDTH-1:0];
    end else if (w_scaled < SAT_MIN) begin
      w_sat = SAT_MIN[OUTPUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_next = MAC;
      MAC:     if (w_last_tap)   w_state_next = ROUND;
      ROUND:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_dline[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tap       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_dline[r_wr_ptr] <= bus.in_data;
            r_rd_ptr          <= r_wr_ptr;
            r_wr_ptr          <= ptr_inc(r_wr_ptr);
            r_acc             <= '0;
            r_tap             <= '0;
          end
        end
        MAC: begin
          // Reading backwards from the newest sample pairs x[n-k] with c[k]
          r_acc    <= r_acc + ACC_W'(w_prod);
          r_tap    <= r_tap + PTR_W'(1);
          r_rd_ptr <= ptr_dec(r_rd_ptr);
        end
        ROUND: begin
          r_out_data  <= w_sat;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != IDLE);
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb/tb_cic_comp_fir.sv - directed vector bench for cic_comp_fir (16-bit and 15-bit output builds)
module tb_cic_comp_fir;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cic_comp_fir_if #(.INPUT_WIDTH(15), .OUTPUT_WIDTH(16)) a_if ();
  cic_comp_fir_if #(.INPUT_WIDTH(15), .OUTPUT_WIDTH(15)) b_if ();

  cic_comp_fir #(.INPUT_WIDTH(15), .OUTPUT_WIDTH(16)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  cic_comp_fir #(.INPUT_WIDTH(15), .OUTPUT_WIDTH(15)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  typedef struct {
    logic signed [14:0] din;
    int                 exp;
  } vec_t;

  vec_t vecs [24];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One strobe, then 15 idle cycles; captures the first out_valid seen
  task automatic run_sample(input bit sel, input logic signed [14:0] x, output int y, output bit got);
    if (sel) begin
      b_if.in_data = x; b_if.in_valid = 1'b1;
    end else begin
      a_if.in_data = x; a_if.in_valid = 1'b1;
    end
    tick();
    a_if.in_valid = 1'b0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0;
    got = 1'b0;
    y   = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (!got) begin
        if (!sel && a_if.out_valid) begin
          got = 1'b1; y = int'(a_if.out_data);
        end else if (sel && b_if.out_valid) begin
          got = 1'b1; y = int'(b_if.out_data);
        end
      end
    end
  endtask

  initial begin
    int   y;
    bit   got;
    int   held;
    int   pulses;
    int   dc_exp [12];
    int   imp_exp [12];

    reset = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0;
    repeat (3) tick();
    check("reset_out_data",  int'(a_if.out_data), 0);
    check("reset_out_valid", int'(a_if.out_valid), 0);
    check("reset_busy",      int'(a_if.busy), 0);
    check("reset_overrun",   int'(a_if.overrun), 0);
    reset = 1'b0;
    tick();

    imp_exp = '{-4, 12, -39, 94, -187, 1250, -187, 94, -39, 12, -4, 0};
    dc_exp  = '{-4, 8, -31, 63, -125, 1125, 938, 1031, 992, 1004, 1000, 1000};
    for (int i = 0; i < 12; i++) begin
      vecs[i].din      = (i == 0) ? 15'sd1000 : 15'sd0;
      vecs[i].exp      = imp_exp[i];
      vecs[12 + i].din = 15'sd1000;
      vecs[12 + i].exp = dc_exp[i];
    end

    for (int i = 0; i < 24; i++) begin
      run_sample(1'b0, vecs[i].din, y, got);
      check($sformatf("vec%0d_valid", i), int'(got), 1);
      check($sformatf("vec%0d_data", i), y, vecs[i].exp);
    end

    // Latency: busy spans T+1..T+12, out_valid only at T+13, data held until then
    held = int'(a_if.out_data);
    a_if.in_data = 15'sd0; a_if.in_valid = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      a_if.in_valid = 1'b0;
      check($sformatf("lat_busy_c%0d", c), int'(a_if.busy), (c <= 12) ? 1 : 0);
      check($sformatf("lat_valid_c%0d", c), int'(a_if.out_valid), (c == 13) ? 1 : 0);
      if (c < 13) check($sformatf("lat_hold_c%0d", c), int'(a_if.out_data), held);
    end
    repeat (2) tick();

    // Overrun: second strobe at cycle 5 is dropped and leaves the history alone
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    a_if.in_data = 15'sd1000; a_if.in_valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      a_if.in_valid = 1'b0;
      if (c <= 5) check($sformatf("ovr_low_c%0d", c), int'(a_if.overrun), 0);
      else        check($sformatf("ovr_high_c%0d", c), int'(a_if.overrun), 1);
      if (c == 5) begin
        a_if.in_data = 15'sd5000; a_if.in_valid = 1'b1;
      end
      if (c == 13) begin
        check("ovr_out_valid", int'(a_if.out_valid), 1);
        check("ovr_out_data", int'(a_if.out_data), -4);
      end
    end
    a_if.in_data = '0;
    repeat (2) tick();
    run_sample(1'b0, 15'sd0, y, got);
    check("ovr_next_valid", int'(got), 1);
    check("ovr_next_data", y, 12);
    check("ovr_sticky", int'(a_if.overrun), 1);

    // Reset mid-pass at T+6 drops the pass and clears every output
    a_if.in_data = 15'sd1000; a_if.in_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      a_if.in_valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("rst_mid_busy",      int'(a_if.busy), 0);
    check("rst_mid_out_valid", int'(a_if.out_valid), 0);
    check("rst_mid_out_data",  int'(a_if.out_data), 0);
    check("rst_mid_overrun",   int'(a_if.overrun), 0);
    tick(); tick();
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (a_if.out_valid) pulses++;
    end
    check("rst_mid_no_valid", pulses, 0);
    for (int i = 0; i < 12; i++) begin
      run_sample(1'b0, vecs[i].din, y, got);
      check($sformatf("replay%0d_valid", i), int'(got), 1);
      check($sformatf("replay%0d_data", i), y, vecs[i].exp);
    end

    // Saturation on the 15-bit output build
    for (int i = 0; i < 24; i++) begin
      run_sample(1'b1, (i == 0) ? 15'sd16383 : ((i == 12) ? -15'sd16384 : 15'sd0), y, got);
      check($sformatf("sat%0d_valid", i), int'(got), 1);
      if (i == 0)  check("sat_pos_tap0",   y, -64);
      if (i == 5)  check("sat_pos_centre", y, 16383);
      if (i == 6)  check("sat_pos_tap6",   y, -3072);
      if (i == 12) check("sat_neg_tap0",   y, 64);
      if (i == 17) check("sat_neg_centre", y, -16384);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Compensation FIR placed directly downstream of the 2-stage CIC decimator. It consumes the decimator's output sample and its one-cycle sample strobe. It applies a fixed 11-tap symmetric FIR that flattens the CIC sinc² passband droop, using one time-shared multiplier. It emits one rounded, saturated sample per accepted input sample.

## Interface
- INPUT_WIDTH, 15, width of signed input sample (matches CIC output width)
- OUTPUT_WIDTH, 16, width of signed output sample
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high; clock clk
- in_valid  in  1  one-cycle strobe, input sample present (driven by the CIC ce_out)
- in_data  in  INPUT_WIDTH  signed input sample, sampled when in_valid=1
- out_data  out  OUTPUT_WIDTH  signed filtered sample, held until next result; reset 0
- out_valid  out  1  one-cycle pulse, out_data updated this cycle; reset 0
- busy  out  1  high while a MAC pass is in progress (state ≠ IDLE); reset 0
- overrun  out  1  sticky, set when a strobe is dropped; cleared only by reset; reset 0

## Operation
- Delay line: 11-entry circular buffer of INPUT_WIDTH words plus a write pointer (0..10, wraps 10→0); reset clears all entries to 0 and the pointer to 0.
- Coefficients are fixed signed 16-bit Q2.14 (COEF_FRAC=14), symmetric: c0..c10 = -64, 192, -640, 1536, -3072, 20480, -3072, 1536, -640, 192, -64. Sum is 16384 (DC gain 1.0).
- FSM states IDLE, MAC, ROUND:
  - IDLE, in_valid=1: write in_data at the pointer, advance the pointer, clear the accumulator, tap index k=0, go to MAC.
  - MAC: acc += x[n-k]·c[k], where x[n] is the newest sample. k runs 0..10, one tap per cycle; after k=10 go to ROUND.
  - ROUND: y = (acc + 2^13) >>> 14 (arithmetic, round half up). Saturate to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1]. Register into out_data, pulse out_valid, go to IDLE.
- Accumulator width is INPUT_WIDTH+16+4 bits, signed; it never overflows internally.
- in_valid while busy=1 (MAC or ROUND): the sample is discarded, overrun is set, and the delay line is untouched.
- Upstream contract: the CIC FACTOR must be ≥ 14 so strobes never collide with a pass.
- Reset mid-pass: the FSM returns to IDLE immediately, the partial result is discarded, and no out_valid is produced.

## Timing
- in_valid at cycle T → MAC during T+1..T+11 → ROUND at T+12 → out_valid and the new out_data visible at T+13.
- busy is high from T+1 through T+12 inclusive. An in_valid at T+13 or later is accepted.
- out_data changes only on cycles where out_valid=1.
- First output after reset uses zeros for the unfilled history.

## Structure
- Package cic_comp_pkg holds:
  - NUM_TAPS=11, COEF_WIDTH=16, COEF_FRAC=14
  - the coefficient constant array
  - the FSM state enum (IDLE, MAC, ROUND)
- Sub-module cic_comp_coef_rom: combinational lookup, tap index → coefficient. Keeping it separate lets a future coefficient set drop in.
- Top level holds the delay-line RAM, pointers, FSM, MAC and round/saturate logic.

## Test plan
- Impulse: in_data=1000 for one strobe, then zeros every 16 cycles. The 11 out_data values are -4, 12, -39, 94, -187, 1250, -187, 94, -39, 12, -4, then 0.
- DC: constant 1000 every 16 cycles. From the 11th output onward out_data=1000.
- Latency: strobe at cycle 100 → out_valid exactly at cycle 113, busy high for cycles 101–112, single-cycle out_valid pulse.
- Overrun: strobes at cycles 0 and 5. The second is dropped and overrun=1 from cycle 6 and stays high. The next output equals a single-strobe result.
- Saturation (OUTPUT_WIDTH=15): impulse 16383 → the centre-tap output clamps to 16383. Impulse -16384 → the centre-tap output clamps to -16384.
- Reset mid-pass: assert reset at T+6. There is no out_valid, and all outputs, busy and overrun are 0. A subsequent impulse of 1000 reproduces the impulse sequence from zero history.
